nibble_deser: RTL and testbench
===============================

NIBBLE_DESER -- requirements
Module: nibble_deser

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of output word entries; power of two, at least 2.
REQ-002 Parameter LSB_FIRST, default 1, bit order: 1 = first serial bit lands in nibble[0], 0 = first serial bit lands in nibble[3].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous clear of the collector, FIFO and word_count.
REQ-006 bit_in  input  1  serial data bit.
REQ-007 bit_valid  input  1  bit_in is valid this cycle.
REQ-008 bit_ready  output  1  block can accept a bit this cycle.
REQ-009 nibble  output  4  head FIFO word, feeding the downstream 4-bit popcount-2/3 detector input.
REQ-010 nibble_valid  output  1  nibble holds a valid word.
REQ-011 out_ready  input  1  downstream consumes nibble this cycle.
REQ-012 bit_count  output  2  number of bits held in the partial word (0..3).
REQ-013 word_count  output  8  total words pushed into the FIFO, modulo 256.

Function
REQ-014 The block SHALL accept a bit on a rising edge where bit_valid && bit_ready && !flush.
REQ-015 The block SHALL drive bit_ready = !(bit_count == 3 && FIFO full), computed from registered state only, with no combinational path from out_ready or bit_valid.
REQ-016 For each accepted bit, the block SHALL store the bit at position bit_count (LSB_FIRST=1) or at position 3-bit_count (LSB_FIRST=0), then increment bit_count.
REQ-017 On the 4th accepted bit (bit_count == 3), the block SHALL push the completed word, including that bit, into the FIFO on the same edge, reset bit_count to 0 and increment word_count.
REQ-018 The block SHALL assert nibble_valid when the FIFO is not empty.
REQ-019 The block SHALL drive nibble from the FIFO head entry.
REQ-020 Latency: a word completed on edge N SHALL appear at nibble with nibble_valid=1 after edge N when the FIFO was empty before edge N.
REQ-021 The block SHALL pop the FIFO head on an edge where nibble_valid && out_ready && !flush.
REQ-022 While nibble_valid=1 and out_ready=0, nibble SHALL remain stable.
REQ-023 Push and pop on the same edge SHALL be legal whenever the push is permitted; FIFO occupancy SHALL then be unchanged and word order preserved.
REQ-024 When the FIFO is full and bit_count == 3, a bit SHALL NOT be accepted, even if a pop occurs on the same edge; the bit is accepted on the first edge after the occupancy falls.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter of width clog2(FIFO_DEPTH)+1.
REQ-026 word_count SHALL wrap from 255 to 0 without any flag.
REQ-027 flush SHALL have priority over bit acceptance and pop, clearing bit_count, the partial word, the FIFO occupancy/pointers and word_count on that edge.
REQ-028 The state encoding SHALL be bit_count itself: states COLLECT0..COLLECT3, advancing one state per accepted bit, and returning COLLECT3 -> COLLECT0 on push or flush.

Reset
REQ-029 On rst=1, the block SHALL immediately (asynchronously) clear bit_count=0, partial word=0, the FIFO to empty, word_count=0, nibble_valid=0 and nibble=4'b0000.
REQ-030 bit_ready SHALL be 1 during and after reset.
REQ-031 Reset asserted mid-word or with FIFO entries pending SHALL discard all held data; no word SHALL be emitted after release.
REQ-032 The first edge after rst falls SHALL operate normally.

Verification
REQ-033 The bench SHALL cover: LSB_FIRST=1, bits 1,1,0,0 with out_ready=1 -> nibble=4'b0011 with nibble_valid=1 for one cycle the edge after the 4th bit, word_count=1 (downstream o=1).
REQ-034 The bench SHALL cover: LSB_FIRST=0, bits 1,0,0,0 -> nibble=4'b1000, word_count=1.
REQ-035 The bench SHALL cover: out_ready=0 with 12 bits streamed -> two words held, bit_ready=0 once bit_count=3, nibble stable at the first word; then out_ready=1 -> words drain in order and the 12th bit is accepted the edge after the first pop.
REQ-036 The bench SHALL cover: full FIFO plus simultaneous pop and 4th bit -> bit refused that edge, accepted next edge, occupancy correct.
REQ-037 The bench SHALL cover: flush asserted with bit_count=2 and one word queued, together with bit_valid=1 -> bit_count=0, nibble_valid=0, word_count=0, bit not captured.
REQ-038 The bench SHALL cover: 256 words pushed -> word_count wraps to 0; and async rst pulsed between clock edges mid-word -> outputs clear immediately, before the next edge.

Source files
------------

// File: rtl/nibble_deser.sv
// Serial-to-nibble deserializer: collects four accepted bits into a word and
// queues completed words in a small FIFO for a 4-bit downstream consumer.
module nibble_deser #(
  parameter int FIFO_DEPTH = 2,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [3:0] nibble,
  output logic       nibble_valid,
  input  logic       out_ready,
  output logic [1:0] bit_count,
  output logic [7:0] word_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    COLLECT0 = 2'd0,
    COLLECT1 = 2'd1,
    COLLECT2 = 2'd2,
    COLLECT3 = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       partial_r;
  logic [3:0]       partial_s;
  logic [3:0]       word_s;
  logic [1:0]       bit_pos_s;
  logic [3:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] occ_r;
  logic [7:0]       word_count_r;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             ready_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;

  // Handshake decode; readiness depends only on registered state.
  always_comb begin
    fifo_full_s  = (occ_r == DEPTH_C);
    fifo_empty_s = (occ_r == {CNT_W{1'b0}});
    ready_s      = !((state_r == COLLECT3) && fifo_full_s);
    accept_s     = bit_valid && ready_s && !flush;
    push_s       = accept_s && (state_r == COLLECT3);
    pop_s        = !fifo_empty_s && out_ready && !flush;
  end

  // Slot the incoming bit occupies within the word being collected.
  always_comb begin
    bit_pos_s = 2'd0;
    if (LSB_FIRST) begin
      bit_pos_s = 2'(state_r);
    end else begin
      bit_pos_s = 2'd3 - 2'(state_r);
    end
  end

  // Collector next-state: bit_count is the state, COLLECT3 wraps on push.
  always_comb begin
    state_s           = state_r;
    partial_s         = partial_r;
    word_s            = partial_r;
    word_s[bit_pos_s] = bit_in;
    if (flush) begin
      state_s   = COLLECT0;
      partial_s = 4'b0000;
    end else if (accept_s) begin
      case (state_r)
        COLLECT0: state_s = COLLECT1;
        COLLECT1: state_s = COLLECT2;
        COLLECT2: state_s = COLLECT3;
        COLLECT3: state_s = COLLECT0;
        default:  state_s = COLLECT0;
      endcase
      if (state_r == COLLECT3) begin
        partial_s = 4'b0000;
      end else begin
        partial_s = word_s;
      end
    end else begin
      state_s   = state_r;
      partial_s = partial_r;
    end
  end

  // Collector state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= COLLECT0;
      partial_r <= 4'b0000;
    end else begin
      state_r   <= state_s;
      partial_r <= partial_s;
    end
  end

  // Word storage; the completed word is written on the same edge as the 4th bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 4'b0000;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // FIFO pointers, occupancy and the pushed-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      occ_r        <= {CNT_W{1'b0}};
      word_count_r <= 8'd0;
    end else if (flush) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      occ_r        <= {CNT_W{1'b0}};
      word_count_r <= 8'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r     <= wr_ptr_r + PTR_W'(1);
        word_count_r <= word_count_r + 8'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CNT_W'(1);
        2'b01:   occ_r <= occ_r - CNT_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Output view of registered state; nibble reads as zero while empty.
  always_comb begin
    bit_ready    = ready_s;
    nibble_valid = !fifo_empty_s;
    bit_count    = 2'(state_r);
    word_count   = word_count_r;
    if (fifo_empty_s) begin
      nibble = 4'b0000;
    end else begin
      nibble = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_nibble_deser.sv
// Randomized and directed bench for nibble_deser: both bit orders run side by
// side against a queue-based model of the bit stream and word FIFO.
module tb_nibble_deser;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       bit_in;
  logic       bit_valid;
  logic       out_ready;
  logic       a_bit_ready, b_bit_ready;
  logic [3:0] a_nibble, b_nibble;
  logic       a_nibble_valid, b_nibble_valid;
  logic [1:0] a_bit_count, b_bit_count;
  logic [7:0] a_word_count, b_word_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  nibble_deser #(.FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(a_bit_ready), .nibble(a_nibble), .nibble_valid(a_nibble_valid),
    .out_ready(out_ready), .bit_count(a_bit_count), .word_count(a_word_count)
  );

  nibble_deser #(.FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(b_bit_ready), .nibble(b_nibble), .nibble_valid(b_nibble_valid),
    .out_ready(out_ready), .bit_count(b_bit_count), .word_count(b_word_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: words kept in arrival order (bit i = i-th received bit).
  logic [3:0] mq[$];
  bit         mbits[$];
  int         mwc = 0;
  bit         m_rdy, m_pop, m_acc;
  logic [3:0] m_word;

  function automatic logic [3:0] rev4(input logic [3:0] w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      mq.delete();
      mbits.delete();
      mwc = 0;
    end else begin
      m_rdy = !(mbits.size() == 3 && mq.size() == DEPTH);
      m_pop = (mq.size() != 0) && out_ready;
      m_acc = bit_valid && m_rdy;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        mbits.push_back(bit_in);
        if (mbits.size() == 4) begin
          m_word = {mbits[3], mbits[2], mbits[1], mbits[0]};
          mq.push_back(m_word);
          mbits.delete();
          mwc = (mwc + 1) % 256;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("a_bit_ready", a_bit_ready, int'(!(mbits.size() == 3 && mq.size() == DEPTH)));
    chk("b_bit_ready", b_bit_ready, int'(!(mbits.size() == 3 && mq.size() == DEPTH)));
    chk("a_bit_count", a_bit_count, mbits.size());
    chk("b_bit_count", b_bit_count, mbits.size());
    chk("a_word_count", a_word_count, mwc);
    chk("b_word_count", b_word_count, mwc);
    chk("a_nibble_valid", a_nibble_valid, int'(mq.size() != 0));
    chk("b_nibble_valid", b_nibble_valid, int'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("a_nibble", a_nibble, mq[0]);
      chk("b_nibble", b_nibble, rev4(mq[0]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic bv, input logic b, input logic ordy, input logic fl);
    bit_valid = bv;
    bit_in    = b;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic send(input logic b, input logic ordy);
    drive(1'b1, b, ordy, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [11:0] stream12;

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    tick();
    chk("rst_bit_ready", a_bit_ready, 1);
    chk("rst_nibble_valid", a_nibble_valid, 0);
    chk("rst_nibble", a_nibble, 0);
    chk("rst_word_count", a_word_count, 0);
    chk("rst_bit_count", a_bit_count, 0);
    tick();
    rst = 1'b0;

    // LSB-first 1,1,0,0 with consumer ready.
    send(1'b1, 1'b1); send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1);
    chk("lsb_nibble", a_nibble, 4'b0011);
    chk("lsb_valid", a_nibble_valid, 1);
    chk("lsb_word_count", a_word_count, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("lsb_valid_one_cycle", a_nibble_valid, 0);

    // MSB-first 1,0,0,0.
    do_reset();
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
    chk("msb_nibble", b_nibble, 4'b1000);
    chk("msb_lsb_nibble", a_nibble, 4'b0001);
    chk("msb_word_count", b_word_count, 1);

    // Backpressure: 12 bits with consumer stalled, then drain.
    do_reset();
    stream12 = 12'b1100_0111_0101;  // bit 0 sent first
    for (int i = 0; i < 11; i++) send(stream12[i], 1'b0);
    chk("bp_bit_count", a_bit_count, 3);
    chk("bp_bit_ready", a_bit_ready, 0);
    chk("bp_head", a_nibble, 4'b0101);
    chk("bp_head_msb", b_nibble, 4'b1010);
    chk("bp_word_count", a_word_count, 2);
    drive(1'b1, stream12[11], 1'b0, 1'b0);
    tick();
    chk("bp_stable", a_nibble, 4'b0101);
    chk("bp_refused", a_bit_count, 3);
    drive(1'b1, stream12[11], 1'b1, 1'b0);
    tick();
    chk("pop_refuse_bc", a_bit_count, 3);
    chk("pop_refuse_head", a_nibble, 4'b0111);
    chk("pop_refuse_ready", a_bit_ready, 1);
    tick();
    chk("next_accept_bc", a_bit_count, 0);
    chk("next_accept_wc", a_word_count, 3);
    chk("next_accept_head", a_nibble, 4'b1100);
    chk("next_accept_head_msb", b_nibble, 4'b0011);
    chk("next_accept_valid", a_nibble_valid, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("drained", a_nibble_valid, 0);

    // Flush with bit_count=2, one word queued, and a bit offered.
    do_reset();
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    send(1'b1, 1'b0); send(1'b1, 1'b0);
    chk("pre_flush_bc", a_bit_count, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("flush_bc", a_bit_count, 0);
    chk("flush_valid", a_nibble_valid, 0);
    chk("flush_wc", a_word_count, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("flush_no_capture", a_bit_count, 0);

    // 256 words: word_count wraps to zero.
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      send(1'($urandom_range(0, 1)), 1'b1);
      if (i == 1019) chk("wc_255", a_word_count, 255);
    end
    chk("wc_wrap", a_word_count, 0);

    // Async reset pulsed between edges, mid-word with a word pending.
    do_reset();
    for (int i = 0; i < 6; i++) send(1'($urandom_range(0, 1)), 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", a_nibble_valid, 0);
    chk("async_nibble", a_nibble, 0);
    chk("async_bc", a_bit_count, 0);
    chk("async_wc", a_word_count, 0);
    chk("async_ready", a_bit_ready, 1);
    chk("async_valid_b", b_nibble_valid, 0);
    #1 rst = 1'b0;
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("post_rst_valid", a_nibble_valid, 0);
    chk("post_rst_bc", a_bit_count, 0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
